// File: rtl/decoder_scan_seq_pkg.sv
// decoder_scan_pkg: shared types and constants for the decoder scan sequencer.
//   NUM_CH / SEL_W : channel count of the downstream 3-to-8 decoder and select width
//   state_t        : sequencer FSM state
//   lowest_set()   : index of the lowest set bit of a channel mask (0 for an empty mask)
package decoder_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_seq_if.sv
// decoder_scan_seq_if: control/status bundle between a host and the scan sequencer.
//   master : drives start, stop, mode, dwell, ch_mask; observes sel, en, busy, ch_tick, done
//   slave  : the sequencer side (inputs/outputs mirrored)
interface decoder_scan_seq_if
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
);

  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  ch_mask;
  logic [SEL_W-1:0]   sel;
  logic               en;
  logic               busy;
  logic               ch_tick;
  logic               done;

  modport master (
    output start, stop, mode, dwell, ch_mask,
    input  sel, en, busy, ch_tick, done
  );

  modport slave (
    input  start, stop, mode, dwell, ch_mask,
    output sel, en, busy, ch_tick, done
  );

endinterface

// File: rtl/decoder_scan_seq_next_ch_find.sv
// next_ch_find: combinational next-channel search.
//   mask     in  8  channels that are visited
//   sel      in  3  current channel
//   next_sel out 3  next set bit strictly above sel, else the lowest set bit
//   wrapped  out 1  no set bit above sel, so the search wrapped around
module next_ch_find
  import decoder_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  next_sel,
  output logic              wrapped
);

  logic [SEL_W-1:0] above;
  logic             found;

  always_comb begin
    above = '0;
    found = 1'b0;
    // Scanning downward leaves the lowest qualifying index in 'above'.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(sel))) begin
        above = SEL_W'(i);
        found = 1'b1;
      end
    end
    next_sel = found ? above : lowest_set(mask);
    wrapped  = ~found;
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: steps the 3-to-8 decoder through a masked subset of channels,
// holding each for a programmable dwell with enable-low blanking in between.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : decoder_scan_seq_if.slave (start/stop/mode/dwell/ch_mask in,
//                sel/en/busy/ch_tick/done out, all outputs registered)
//
//   state  | meaning
//   IDLE   | waiting for start, en = 0, sel = 0
//   ACTIVE | en = 1 on the current channel for max(dwell,1) cycles
//   BLANK  | en = 0 for BLANK_CYCLES cycles, sel already on the next channel
module decoder_scan_seq
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  decoder_scan_seq_if.slave bus
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic               en_q;
  logic               busy_q;
  logic               tick_q;
  logic               done_q;
  logic               mode_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [DWELL_W-1:0] dwell_load;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [BW-1:0]      blank_cnt;

  logic [SEL_W-1:0]   next_sel;
  logic               wrapped;
  logic [DWELL_W-1:0] start_load;

  // Counter runs D-1 down to 0, so dwell = 0 behaves like 1 and the maximum never wraps.
  assign start_load = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

  next_ch_find u_next (
    .mask     (mask_q),
    .sel      (sel_q),
    .next_sel (next_sel),
    .wrapped  (wrapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
      mask_q     <= '0;
      dwell_load <= '0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop && (bus.ch_mask != '0)) begin
            state      <= ACTIVE;
            sel_q      <= lowest_set(bus.ch_mask);
            en_q       <= 1'b1;
            busy_q     <= 1'b1;
            tick_q     <= 1'b1;
            mode_q     <= bus.mode;
            mask_q     <= bus.ch_mask;
            dwell_load <= start_load;
            dwell_cnt  <= start_load;
          end
        end
        ACTIVE: begin
          if (bus.stop) begin
            state  <= IDLE;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else if (mode_q && wrapped) begin
            // Wrapping out of the highest set channel ends a single sweep.
            state  <= IDLE;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (BLANK_CYCLES > 0) begin
            state     <= BLANK;
            sel_q     <= next_sel;
            en_q      <= 1'b0;
            blank_cnt <= BLANK_LOAD;
          end else begin
            sel_q     <= next_sel;
            tick_q    <= 1'b1;
            dwell_cnt <= dwell_load;
          end
        end
        BLANK: begin
          if (bus.stop) begin
            state  <= IDLE;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
          end else begin
            state     <= ACTIVE;
            en_q      <= 1'b1;
            tick_q    <= 1'b1;
            dwell_cnt <= dwell_load;
          end
        end
        default: begin
          state  <= IDLE;
          sel_q  <= '0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.busy    = busy_q;
  assign bus.ch_tick = tick_q;
  assign bus.done    = done_q;

endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Sequencer that sits directly upstream of the 3-to-8 structural decoder and drives its select (A, B, C) and enable inputs. It steps through a programmable subset of the 8 decoder outputs, holding each for a programmable dwell time. Between channels it inserts enable-low blanking so the decoder never glitches from one output to another. It supports continuous round-robin scanning and single-sweep operation with a completion pulse.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell-count input.
- BLANK_CYCLES, 2, enable-low cycles between channels; 0 means no blanking.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan; level sampled each cycle, only acted on in IDLE.
- stop  in  1  abort the scan and return to IDLE.
- mode  in  1  0 = continuous round-robin, 1 = single sweep.
- dwell  in  DWELL_W  enable-high cycles per channel; 0 is treated as 1.
- ch_mask  in  8  bit i = 1 means channel i is visited.
- sel  out  3  channel index; sel[2] drives A, sel[1] drives B, sel[0] drives C.
- en  out  1  drives the decoder enable.
- busy  out  1  high in any state other than IDLE.
- ch_tick  out  1  one-cycle pulse on the first ACTIVE cycle of each channel.
- done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- Reset (asynchronous, rst_n low): state = IDLE; sel = 0, en = 0, busy = 0, ch_tick = 0, done = 0.
- mode, dwell and ch_mask are captured on the accepted start. Changes during a scan are ignored.
- The state machine has three states: IDLE, ACTIVE and BLANK.
- IDLE behaviour:
  - On start = 1, stop = 0 and ch_mask != 0: go to ACTIVE, with sel = the lowest set bit of ch_mask.
  - start with ch_mask = 0 is ignored: the block stays in IDLE and no outputs change.
- ACTIVE behaviour:
  - en = 1 for D = max(dwell, 1) cycles.
  - ch_tick = 1 on the first of those cycles.
  - After the Dth cycle, one of the following applies:
    - Single mode on the highest set channel: go to IDLE, with done = 1 for one cycle, sel = 0 and en = 0.
    - Otherwise, when BLANK_CYCLES > 0: go to BLANK, and sel updates to the next set channel on BLANK entry.
    - Otherwise, when BLANK_CYCLES = 0: go directly to ACTIVE on the next channel, with a fresh ch_tick.
- Next-channel search: the next set bit of the captured mask strictly above sel, wrapping to the lowest set bit.
  - With exactly one bit set, the next channel is the same channel.
- BLANK behaviour: en = 0 for BLANK_CYCLES cycles, then go to ACTIVE. sel is stable throughout BLANK.
- stop in any non-IDLE state:
  - Next cycle: IDLE, with en = 0 and sel = 0.
  - No done pulse is generated.
- start and stop asserted in the same cycle: stop wins and the scan does not begin.
- start while busy is ignored.

## Timing
- Latency from start to en: start is sampled high at edge N, and en = 1 with the correct sel is visible after edge N.
- Channel period:
  - D + BLANK_CYCLES cycles.
  - A single sweep of k enabled channels lasts k·D + (k−1)·BLANK_CYCLES cycles of busy.
- sel never changes while en = 1. sel changes only:
  - on the ACTIVE→BLANK edge;
  - on the ACTIVE→ACTIVE edge when BLANK_CYCLES = 0;
  - on the IDLE entry/exit edges.
- The dwell counter is DWELL_W bits and counts from D−1 down to 0. It never wraps: dwell = 2^DWELL_W − 1 gives exactly that many cycles.
- done and ch_tick are registered outputs and are never high for more than one consecutive cycle per event.
- busy falls on the same edge that done rises.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `decoder_scan_pkg`:
  - NUM_CH = 8 and SEL_W = 3;
  - the state enum (IDLE, ACTIVE, BLANK).
- Sub-module `next_ch_find`:
  - purely combinational;
  - inputs: 8-bit mask and 3-bit current sel;
  - outputs: 3-bit next sel and a wrapped flag.
  - The top level uses the wrapped flag together with mode to detect the end of a single sweep.
- The decoder itself is not instantiated here. Integration wires sel/en to the decoder's A, B, C and en inputs.

## Test plan
- Reset mid-ACTIVE with dwell = 5 and mask = 8'hFF: rst_n low at cycle 2 of ACTIVE. Required: en = 0, sel = 0 and busy = 0 immediately, with no done pulse.
- Continuous scan, mask = 8'b1010_0101, dwell = 3, BLANK_CYCLES = 2. Required:
  - sel sequence is 0, 2, 5, 7, 0, …;
  - each channel shows en high for 3 cycles, then low for 2;
  - ch_tick occurs every 5 cycles.
- Single sweep, mask = 8'h81, dwell = 0. Required:
  - ch0 for 1 cycle, 2 blank cycles, then ch7 for 1 cycle;
  - done pulses on the following cycle;
  - busy is high for exactly 4 cycles.
- Single-bit mask 8'h10 in continuous mode, dwell = 2. Required: sel stays at 4 throughout, and en repeats high-high-low-low.
- start and stop asserted together in IDLE: no transition. Then stop during BLANK: IDLE on the next cycle, with no done pulse.
- start with mask = 0: busy stays 0. Changing ch_mask mid-scan from 8'hFF to 8'h01 does not alter the sweep sequence.
